// File: rtl/cnt_seg7_scan.sv
// Two-digit multiplexed 7-segment display stage for an upstream counter.
// Samples the count, converts it to BCD and scans the two digits alternately.
module cnt_seg7_scan #(
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned REFRESH_DIV = 4,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             cnt_valid,
  input  logic             hold,
  output logic [6:0]       seg,
  output logic [1:0]       dig_en,
  output logic [3:0]       tens_bcd,
  output logic [3:0]       ones_bcd,
  output logic             changed,
  output logic             ovf
);

  localparam int unsigned PW  = $clog2(REFRESH_DIV);
  localparam int unsigned VW  = 7;

  localparam logic [0:0] S_ONES = 1'b0;
  localparam logic [0:0] S_TENS = 1'b1;

  logic [CNT_W-1:0] r_disp;
  logic [PW-1:0]    r_presc;
  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic             w_tick;
  logic [VW-1:0]    w_val;
  logic             w_sat;
  logic [3:0]       w_tens;
  logic [3:0]       w_ones;
  logic [6:0]       w_seg_nxt;
  logic [1:0]       w_dig_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  // Sample stage: capture the count and flag a change of the held value
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_disp  <= '0;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (cnt_valid && !hold) begin
        r_disp  <= cnt_in;
        changed <= (cnt_in != r_disp);
      end
    end
  end

  // Binary to two-digit BCD with saturation at 99
  always_comb begin
    w_val  = VW'(r_disp);
    w_sat  = (w_val > VW'(99));
    w_tens = w_sat ? 4'd9 : 4'(w_val / VW'(10));
    w_ones = w_sat ? 4'd9 : 4'(w_val % VW'(10));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tens_bcd <= 4'd0;
      ones_bcd <= 4'd0;
      ovf      <= 1'b0;
    end else begin
      tens_bcd <= w_tens;
      ones_bcd <= w_ones;
      ovf      <= w_sat;
    end
  end

  // Free-running refresh prescaler
  assign w_tick = (r_presc == PW'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_ONES;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next digit drive; outputs follow the state held before the edge
  always_comb begin
    w_state_nxt = r_state;
    w_seg_nxt   = 7'h00;
    w_dig_nxt   = 2'b00;
    case (r_state)
      S_ONES: begin
        w_dig_nxt = 2'b01;
        w_seg_nxt = seg_decode(ones_bcd);
        if (w_tick) w_state_nxt = S_TENS;
      end
      S_TENS: begin
        w_dig_nxt = 2'b10;
        w_seg_nxt = (BLANK_LZ && (tens_bcd == 4'd0)) ? 7'h00 : seg_decode(tens_bcd);
        if (w_tick) w_state_nxt = S_ONES;
      end
      default: w_state_nxt = S_ONES;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      seg    <= 7'h00;
      dig_en <= 2'b00;
    end else begin
      seg    <= w_seg_nxt;
      dig_en <= w_dig_nxt;
    end
  end

endmodule

// File: tb/tb_cnt_seg7_scan.sv
// Bench for cnt_seg7_scan: directed scenarios plus random traffic, checked every
// cycle against a value-pipeline model; a second instance shows leading zeros.
module tb_cnt_seg7_scan;

  localparam int unsigned CNT_W = 5;
  localparam int unsigned RD    = 4;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] cnt_in;
  logic             cnt_valid;
  logic             hold;

  logic [6:0] seg,      seg0;
  logic [1:0] dig_en,   dig_en0;
  logic [3:0] tens_bcd, tens_bcd0;
  logic [3:0] ones_bcd, ones_bcd0;
  logic       changed,  changed0;
  logic       ovf,      ovf0;

  int n_cmp;
  int n_err;

  // Model state: value held in the sample register, value feeding the BCD
  // registers, and number of edges since reset release.
  int m_disp;
  int m_src;
  int m_k;
  int e_seg, e_seg0, e_dig, e_t, e_o, e_chg, e_ovf;

  cnt_seg7_scan #(.CNT_W(CNT_W), .REFRESH_DIV(RD), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .hold(hold),
    .seg(seg), .dig_en(dig_en), .tens_bcd(tens_bcd), .ones_bcd(ones_bcd),
    .changed(changed), .ovf(ovf)
  );

  cnt_seg7_scan #(.CNT_W(CNT_W), .REFRESH_DIV(RD), .BLANK_LZ(1'b0)) dut_lz (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .hold(hold),
    .seg(seg0), .dig_en(dig_en0), .tens_bcd(tens_bcd0), .ones_bcd(ones_bcd0),
    .changed(changed0), .ovf(ovf0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int dec7(input int d);
    case (d)
      0: dec7 = 'h3F; 1: dec7 = 'h06; 2: dec7 = 'h5B; 3: dec7 = 'h4F; 4: dec7 = 'h66;
      5: dec7 = 'h6D; 6: dec7 = 'h7D; 7: dec7 = 'h07; 8: dec7 = 'h7F; 9: dec7 = 'h6F;
      default: dec7 = 0;
    endcase
  endfunction

  function automatic int tens_of(input int v);
    tens_of = (v > 99) ? 9 : v / 10;
  endfunction

  function automatic int ones_of(input int v);
    ones_of = (v > 99) ? 9 : v % 10;
  endfunction

  // One clock: drive inputs, advance the model by one edge, compare every output
  task automatic cyc(input bit r, input bit v, input bit h, input int c);
    int  cm;
    int  t;
    int  o;
    bit  tens_ph;
    cm = c % (1 << CNT_W);
    @(negedge clk);
    rst = r; cnt_valid = v; hold = h; cnt_in = CNT_W'(cm);
    @(posedge clk);
    #1;
    if (!r) begin
      m_disp = 0; m_src = 0; m_k = 0;
      e_seg = 0; e_seg0 = 0; e_dig = 0; e_t = 0; e_o = 0; e_chg = 0; e_ovf = 0;
    end else begin
      t = tens_of(m_src);
      o = ones_of(m_src);
      tens_ph = ((m_k / RD) % 2) == 1;
      e_dig  = tens_ph ? 2 : 1;
      e_seg0 = tens_ph ? dec7(t) : dec7(o);
      e_seg  = (tens_ph && t == 0) ? 0 : e_seg0;
      m_src  = m_disp;
      e_t    = tens_of(m_src);
      e_o    = ones_of(m_src);
      e_ovf  = (m_src > 99) ? 1 : 0;
      e_chg  = (v && !h && cm != m_disp) ? 1 : 0;
      if (v && !h) m_disp = cm;
      m_k++;
    end
    chk("seg",      int'(seg),      e_seg);
    chk("dig_en",   int'(dig_en),   e_dig);
    chk("tens_bcd", int'(tens_bcd), e_t);
    chk("ones_bcd", int'(ones_bcd), e_o);
    chk("changed",  int'(changed),  e_chg);
    chk("ovf",      int'(ovf),      e_ovf);
    chk("lz_seg",   int'(seg0),     e_seg0);
    chk("lz_dig",   int'(dig_en0),  e_dig);
    chk("lz_tens",  int'(tens_bcd0), e_t);
    chk("lz_ones",  int'(ones_bcd0), e_o);
    chk("lz_chg",   int'(changed0), e_chg);
    chk("lz_ovf",   int'(ovf0),     e_ovf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, int'($urandom_range(0, 31)));
  endtask

  initial begin
    int  waited;
    n_cmp = 0; n_err = 0;
    m_disp = 0; m_src = 0; m_k = 0;
    rst = 1'b0; cnt_valid = 1'b0; hold = 1'b0; cnt_in = '0;

    // Reset held for three cycles, then release
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 23);
    cyc(1'b1, 1'b0, 1'b0, 0);
    chk("rel_dig", int'(dig_en), 1);
    chk("rel_seg", int'(seg), 'h3F);
    idle(RD);
    chk("rel_tens_dig", int'(dig_en), 2);
    chk("rel_tens_blank", int'(seg), 0);
    idle(RD);

    // Sample 23
    cyc(1'b1, 1'b1, 1'b0, 23);
    chk("s23_chg", int'(changed), 1);
    cyc(1'b1, 1'b0, 1'b0, 0);
    chk("s23_chg_off", int'(changed), 0);
    chk("s23_tens", int'(tens_bcd), 2);
    chk("s23_ones", int'(ones_bcd), 3);
    idle(3 * RD);

    // Leading zero: 7
    cyc(1'b1, 1'b1, 1'b0, 7);
    idle(3 * RD);

    // Hold overrides valid; resampling the same value is not a change
    cyc(1'b1, 1'b1, 1'b0, 31);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 12);
    chk("hold_chg", int'(changed), 0);
    chk("hold_tens", int'(tens_bcd), 3);
    chk("hold_ones", int'(ones_bcd), 1);
    cyc(1'b1, 1'b1, 1'b0, 31);
    chk("resample_chg", int'(changed), 0);
    idle(RD);

    // Upstream count 1..31 then wrap to 0, sampled every cycle
    for (int i = 1; i <= 32; i++) cyc(1'b1, 1'b1, 1'b0, i % 32);
    chk("wrap_chg", int'(changed), 1);
    idle(3 * RD);

    // Reset during the tens phase with 23 displayed
    cyc(1'b1, 1'b1, 1'b0, 23);
    waited = 0;
    while (dig_en != 2'b10 && waited < 4 * RD) begin
      cyc(1'b1, 1'b0, 1'b0, 0);
      waited++;
    end
    chk("mid_tens_reached", int'(dig_en), 2);
    cyc(1'b0, 1'b1, 1'b0, 5);
    chk("mid_rst_seg", int'(seg), 0);
    chk("mid_rst_dig", int'(dig_en), 0);
    cyc(1'b1, 1'b0, 1'b0, 0);
    chk("mid_rel_seg", int'(seg), 'h3F);
    idle(3 * RD);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 3) == 0), int'($urandom_range(0, 31)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
